// File: rtl/pc_gen.sv
// Fetch PC generator: picks the next PC from exception, eret, branch, jump,
// a buffered redirect or sequential increment, and captures EPC on exceptions.
module pc_gen #(
   parameter int unsigned  W            = 32,
   parameter logic [31:0]  RESET_VECTOR = 32'h0040_0000,
   parameter logic [31:0]  EXC_VECTOR   = 32'h8000_0180,
   parameter int unsigned  STEP         = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pc_write,
   input  logic         exc_req,
   input  logic         eret,
   input  logic         br_taken,
   input  logic [W-1:0] br_target,
   input  logic         jmp_valid,
   input  logic [W-1:0] jmp_target,
   output logic [W-1:0] pc,
   output logic [W-1:0] pc_plus,
   output logic [W-1:0] epc,
   output logic         redirect_pending,
   output logic         fetch_flush
);

   localparam logic [W-1:0] STEP_W     = W'(STEP);
   localparam logic [W-1:0] ALIGN_MASK = ~(STEP_W - W'(1));
   localparam logic [W-1:0] RESET_PC   = W'(RESET_VECTOR);
   localparam logic [W-1:0] EXC_PC     = W'(EXC_VECTOR) & ALIGN_MASK;

   logic [W-1:0] pc_q, pc_d;
   logic [W-1:0] epc_q, epc_d;
   logic [W-1:0] pend_tgt_q, pend_tgt_d;
   logic         pend_q, pend_d;
   logic         pend_jmp_q, pend_jmp_d;
   logic         flush_q, flush_d;
   logic [W-1:0] br_al, jmp_al;

   assign br_al   = br_target & ALIGN_MASK;
   assign jmp_al  = jmp_target & ALIGN_MASK;
   assign pc_plus = pc_q + STEP_W;

   always_comb begin
      pc_d       = pc_q;
      epc_d      = epc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      pend_jmp_d = pend_jmp_q;
      flush_d    = 1'b0;
      if (exc_req) begin
         pc_d    = EXC_PC;
         epc_d   = pc_q;
         pend_d  = 1'b0;
         flush_d = 1'b1;
      end else if (eret) begin
         pc_d    = epc_q;
         pend_d  = 1'b0;
         flush_d = 1'b1;
      end else if (br_taken) begin
         if (pc_write) begin
            pc_d    = br_al;
            pend_d  = 1'b0;
            flush_d = 1'b1;
         end else begin
            pend_d     = 1'b1;
            pend_tgt_d = br_al;
            pend_jmp_d = 1'b0;
         end
      end else if (jmp_valid) begin
         if (pc_write) begin
            pc_d    = jmp_al;
            pend_d  = 1'b0;
            flush_d = 1'b1;
         end else if (!pend_q || pend_jmp_q) begin
            // a buffered branch is older-path-correct, so a jump never replaces it
            pend_d     = 1'b1;
            pend_tgt_d = jmp_al;
            pend_jmp_d = 1'b1;
         end
      end else if (pend_q && pc_write) begin
         pc_d    = pend_tgt_q;
         pend_d  = 1'b0;
         flush_d = 1'b1;
      end else if (pc_write) begin
         pc_d = pc_plus;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         epc_q      <= '0;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         pend_jmp_q <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         pend_jmp_q <= pend_jmp_d;
         flush_q    <= flush_d;
      end
   end

   assign pc               = pc_q;
   assign epc              = epc_q;
   assign redirect_pending = pend_q;
   assign fetch_flush      = flush_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_pc_gen;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] EXC_PC = 32'h8000_0180;
   localparam int unsigned STEP   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pc_write = 1'b0, exc_req = 1'b0, eret = 1'b0;
   logic        br_taken = 1'b0, jmp_valid = 1'b0;
   logic [31:0] br_target = '0, jmp_target = '0;
   logic [31:0] pc, pc_plus, epc;
   logic        redirect_pending, fetch_flush;

   int vectors = 0;
   int errors  = 0;
   bit check_en = 1'b0;

   pc_gen #(.W(32), .RESET_VECTOR(32'h0040_0000), .EXC_VECTOR(32'h8000_0180), .STEP(4)) dut (
      .clk(clk), .reset(reset), .pc_write(pc_write), .exc_req(exc_req), .eret(eret),
      .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid),
      .jmp_target(jmp_target), .pc(pc), .pc_plus(pc_plus), .epc(epc),
      .redirect_pending(redirect_pending), .fetch_flush(fetch_flush));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: which redirect wins, and whether it is taken now or parked.
   logic [31:0] m_pc, m_epc, m_tgt;
   bit          m_pend, m_pend_is_jmp, m_flush;

   function automatic logic [31:0] align(input logic [31:0] a);
      return a & ~(STEP - 1);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = RST_PC; m_epc = 0; m_tgt = 0;
         m_pend = 0; m_pend_is_jmp = 0; m_flush = 0;
      end else begin
         bit          live, live_is_jmp;
         logic [31:0] live_tgt, old_pc;
         old_pc      = m_pc;
         live        = br_taken || jmp_valid;
         live_is_jmp = !br_taken;
         live_tgt    = br_taken ? align(br_target) : align(jmp_target);
         m_flush     = 0;
         if (exc_req || eret) begin
            m_pc    = exc_req ? EXC_PC : m_epc;
            if (exc_req) m_epc = old_pc;
            m_pend  = 0;
            m_flush = 1;
         end else if (live && pc_write) begin
            m_pc = live_tgt; m_pend = 0; m_flush = 1;
         end else if (live) begin
            if (!(live_is_jmp && m_pend && !m_pend_is_jmp)) begin
               m_tgt = live_tgt; m_pend = 1; m_pend_is_jmp = live_is_jmp;
            end
         end else if (pc_write && m_pend) begin
            m_pc = m_tgt; m_pend = 0; m_flush = 1;
         end else if (pc_write) begin
            m_pc = old_pc + STEP;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en && reset) begin
         chk("model_pc",      pc,                        m_pc);
         chk("model_pc_plus", pc_plus,                   m_pc + STEP);
         chk("model_epc",     epc,                       m_epc);
         chk("model_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
         chk("model_flush",   {31'b0, fetch_flush},      {31'b0, m_flush});
      end
   end

   task automatic cyc(input bit pw, input bit exc, input bit er,
                      input bit br, input logic [31:0] bt,
                      input bit jv, input logic [31:0] jt);
      pc_write = pw; exc_req = exc; eret = er;
      br_taken = br; br_target = bt; jmp_valid = jv; jmp_target = jt;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_en = 1'b1;
      chk("reset_pc", pc, RST_PC);
      chk("reset_epc", epc, 32'h0);
      chk("reset_flush", {31'b0, fetch_flush}, 32'h0);

      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_1", pc, 32'h0040_0004);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_2", pc, 32'h0040_0008);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_3", pc, 32'h0040_000C);
      chk("seq_flush", {31'b0, fetch_flush}, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_4", pc, 32'h0040_0010);

      cyc(1, 0, 0, 1, 32'h0040_0103, 0, 0);
      chk("br_aligned", pc, 32'h0040_0100);
      chk("br_flush", {31'b0, fetch_flush}, 32'h1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("br_flush_end", {31'b0, fetch_flush}, 32'h0);
      chk("after_br", pc, 32'h0040_0104);

      cyc(0, 0, 0, 1, 32'h0040_0200, 0, 0);
      chk("stall_hold", pc, 32'h0040_0104);
      chk("stall_pend", {31'b0, redirect_pending}, 32'h1);
      chk("stall_noflush", {31'b0, fetch_flush}, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 32'h0040_0300);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("stall_hold3", pc, 32'h0040_0104);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("pend_branch_kept", pc, 32'h0040_0200);
      chk("pend_cleared", {31'b0, redirect_pending}, 32'h0);
      chk("pend_flush", {31'b0, fetch_flush}, 32'h1);

      cyc(1, 0, 0, 0, 0, 1, 32'h0040_0020);
      chk("jmp_to_20", pc, 32'h0040_0020);
      cyc(0, 0, 0, 1, 32'h0040_0500, 0, 0);
      chk("pend_before_exc", {31'b0, redirect_pending}, 32'h1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("exc_pc", pc, EXC_PC);
      chk("exc_epc", epc, 32'h0040_0020);
      chk("exc_pend_clr", {31'b0, redirect_pending}, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("handler_seq", pc, 32'h8000_0184);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("eret_pc", pc, 32'h0040_0020);
      chk("eret_flush", {31'b0, fetch_flush}, 32'h1);

      cyc(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_plus", pc_plus, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("wrap_seq", pc, 32'h0);

      // asynchronous reset while stalled with a buffered redirect
      cyc(0, 0, 0, 1, 32'h0040_0600, 0, 0);
      chk("pre_rst_pend", {31'b0, redirect_pending}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("arst_pc", pc, RST_PC);
      chk("arst_pend", {31'b0, redirect_pending}, 32'h0);
      chk("arst_flush", {31'b0, fetch_flush}, 32'h0);
      @(negedge clk); reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0);

      // asynchronous reset while a flush pulse is high
      cyc(1, 0, 0, 0, 0, 1, 32'h0040_0700);
      chk("pre_rst_flush", {31'b0, fetch_flush}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("arst2_flush", {31'b0, fetch_flush}, 32'h0);
      chk("arst2_pc", pc, RST_PC);
      @(negedge clk); reset = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 15), $urandom,
             ($urandom_range(0, 99) < 15), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the plain PC register. Holds the fetch PC and selects the next PC from the following sources: exception vector, exception return, EX-stage branch, ID-stage jump, a buffered redirect, or sequential increment.
- Redirects that arrive while fetch is stalled are buffered rather than lost.
- Captures EPC on exceptions.
- Emits a registered flush pulse to the IF/ID register.
- Sits at the front of the 5-stage pipeline, feeding instruction memory and the IF/ID register.

Parameters:
- W, 32, PC/address width (≥ 8).
- RESET_VECTOR, 32'h00400000, PC value loaded on reset (truncated to W).
- EXC_VECTOR, 32'h80000180, exception/interrupt entry address.
- STEP, 4, sequential increment in bytes (power of two, ≥ 4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_write  in  1  1 = PC may advance; 0 = hazard stall, hold PC.
- exc_req  in  1  exception/interrupt taken this cycle.
- eret  in  1  return from exception.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  W  branch target.
- jmp_valid  in  1  ID-stage jump (j/jal/jr).
- jmp_target  in  W  jump target.
- pc  out  W  current fetch PC.
- pc_plus  out  W  pc + STEP (combinational).
- epc  out  W  PC saved at last exception.
- redirect_pending  out  1  buffered redirect waiting for stall release.
- fetch_flush  out  1  one-cycle pulse after any applied redirect.

Behaviour:
- Reset (async, reset=0): pc=RESET_VECTOR, epc=0, redirect_pending=0, pending target=0, fetch_flush=0. Reset takes effect immediately, even mid-redirect or mid-stall.
- All state updates on the rising clk edge. Outputs are registered except pc_plus.
- Target alignment: the low log2(STEP) bits of br_target, jmp_target and EXC_VECTOR are forced to 0 before use.
- Arithmetic: pc_plus = (pc + STEP) mod 2^W; wraps silently.
- Next-PC priority, highest first:
  1. exc_req: pc<=EXC_VECTOR; epc<=pc. Applies regardless of pc_write. Clears pending.
  2. eret: pc<=epc. Applies regardless of pc_write. Clears pending.
  3. br_taken: if pc_write=1, pc<=br_target and clear pending. If pc_write=0, pending<=br_target and redirect_pending<=1.
  4. jmp_valid: same as br_taken, using jmp_target. If pc_write=0 and a pending entry exists, jmp overwrites it only when that entry came from jmp; a pending branch is never overwritten by a jmp. A pending entry's source (br/jmp) is tracked by an internal bit.
  5. redirect_pending=1 and pc_write=1: pc<=pending target; redirect_pending<=0.
  6. pc_write=1: pc<=pc_plus.
  7. Otherwise: hold.
- Simultaneous br_taken and jmp_valid: br wins and the jmp is dropped (it is on the wrong path).
- A live br/jmp with pc_write=1 beats the pending entry, and the pending entry is discarded.
- A live br with pc_write=0 always overwrites the pending entry.
- epc updates only on exc_req.
- eret with exc_req in the same cycle: exc_req wins, and epc<=pc (the current PC, not the old epc).
- fetch_flush=1 for exactly the cycle after any applied redirect (cases 1, 2, 3/4 applied, 5). It is not asserted when a redirect is only buffered.
- Latency: a redirect is visible on pc one cycle after the request, or one cycle after pc_write returns to 1 if it was buffered.

Test Plan:
- Release reset, pc_write=1 for 3 cycles -> pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; fetch_flush stays 0.
- At pc=0x00400010 assert br_taken with br_target=0x00400103 -> next pc=0x00400100 (alignment applied); fetch_flush=1 for one cycle.
- pc_write=0 for 3 cycles; br_taken pulse with target 0x00400200 in cycle 1; jmp_valid with target 0x00400300 in cycle 2 -> pc held; redirect_pending=1; then pc_write=1 -> pc=0x00400200 (branch not overwritten), redirect_pending=0, flush pulse.
- exc_req at pc=0x00400020 with pc_write=0 and a pending redirect -> pc=0x80000180, epc=0x00400020, pending cleared. Later eret -> pc=0x00400020.
- W=32, STEP=4, force pc to 0xFFFFFFFC via jmp -> next sequential pc=0x00000000.
- Drop reset low mid-stall with a pending redirect -> pc=0x00400000, redirect_pending=0, fetch_flush=0 immediately, without waiting for a clock edge.
